// File: rtl/arb_pkg.sv
// Shared types, defaults and the rotating-priority search
// used by the four-way round-robin arbiter.
package arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   localparam int DEF_MAX_HOLD = 4;
   localparam int CNT_W        = 4;

   // Returns {found, index} of the first set bit from ptr upward, mod 4.
   function automatic logic [2:0] rr_pick(
      input logic [3:0] req,
      input logic [1:0] ptr
   );
      logic [2:0] res;
      logic [1:0] idx;
      res = '0;
      for (int k = 3; k >= 0; k--) begin
         idx = ptr + 2'(k);
         if (req[idx]) res = {1'b1, idx};
      end
      return res;
   endfunction

   function automatic logic [3:0] one_hot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Request/grant bundle between the requesters and the arbiter,
// including the muxed data output.
interface rr_arb4_if;

   logic [3:0] req;
   logic [3:0] din;
   logic [3:0] gnt;
   logic       s1;
   logic       s0;
   logic       busy;
   logic       o;

   modport master (
      output req,
      output din,
      input  gnt,
      input  s1,
      input  s0,
      input  busy,
      input  o
   );

   modport slave (
      input  req,
      input  din,
      output gnt,
      output s1,
      output s0,
      output busy,
      output o
   );

endinterface

// File: rtl/mux41.sv
// Plain 4:1 single-bit multiplexer, select {s1,s0}.
module mux41 (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic s0,
   input  logic s1,
   output logic o
);

   always_comb begin
      o = a;
      unique case ({s1, s0})
         2'b00: o = a;
         2'b01: o = b;
         2'b10: o = c;
         2'b11: o = d;
         default: o = a;
      endcase
   end

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with bounded hold time; the granted
// requester's data bit is routed out through a mux41.
module rr_arb4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input logic   clk,
   input logic   rst_n,
   rr_arb4_if.slave bus
);

   arb_state_e       r_state;
   logic [3:0]       r_gnt;
   logic [1:0]       r_sel;
   logic [1:0]       r_ptr;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;

   logic             w_own_req;
   logic             w_expire;
   logic             w_release;
   logic [1:0]       w_ptr_nxt;
   logic [2:0]       w_pick_idle;
   logic [2:0]       w_pick_rel;
   logic             w_mux;

   assign w_own_req = bus.req[r_sel];
   assign w_expire  = (r_cnt == CNT_W'(MAX_HOLD - 1));
   assign w_release = !w_own_req || w_expire;
   assign w_ptr_nxt = r_sel + 2'd1;

   // The owner is last in order from owner+1, so a lone owner is re-granted.
   assign w_pick_idle = rr_pick(bus.req, r_ptr);
   assign w_pick_rel  = rr_pick(bus.req, w_ptr_nxt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_sel   <= '0;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_pick_idle[2]) begin
                  r_state <= ST_GRANT;
                  r_gnt   <= one_hot(w_pick_idle[1:0]);
                  r_sel   <= w_pick_idle[1:0];
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_gnt  <= '0;
                  r_busy <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!w_release) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else begin
                  r_ptr <= w_ptr_nxt;
                  r_cnt <= '0;
                  if (w_pick_rel[2]) begin
                     r_gnt <= one_hot(w_pick_rel[1:0]);
                     r_sel <= w_pick_rel[1:0];
                  end else begin
                     r_state <= ST_IDLE;
                     r_gnt   <= '0;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   mux41 u_mux (
      .a  (bus.din[0]),
      .b  (bus.din[1]),
      .c  (bus.din[2]),
      .d  (bus.din[3]),
      .s0 (r_sel[0]),
      .s1 (r_sel[1]),
      .o  (w_mux)
   );

   assign bus.gnt  = r_gnt;
   assign bus.s1   = r_sel[1];
   assign bus.s0   = r_sel[0];
   assign bus.busy = r_busy;
   assign bus.o    = r_busy & w_mux;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed scenarios plus random
// traffic compared against an ownership-level reference model.
module tb_rr_arb4;

   localparam int MH = 4;

   logic clk;
   logic rst_n;
   rr_arb4_if bus ();

   rr_arb4 #(.MAX_HOLD(MH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec;
   int n_err;

   int m_owner;
   int m_held;
   int m_ptr;
   int m_sel;

   function automatic int first_from(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] m_gnt();
      logic [3:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_sel   = 0;
   endtask

   task automatic model_step(input logic [3:0] r);
      int w;
      if (m_owner < 0) begin
         w = first_from(r, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
         end
      end else if (r[m_owner] && m_held < MH) begin
         m_held++;
      end else begin
         m_ptr   = (m_owner + 1) % 4;
         w       = first_from(r, m_ptr);
         m_owner = w;
         m_held  = (w >= 0) ? 1 : 0;
      end
      if (m_owner >= 0) m_sel = m_owner;
   endtask

   // Drive inputs, take one rising edge, update the model, settle.
   task automatic step(input logic [3:0] r, input logic [3:0] d);
      bus.req = r;
      bus.din = d;
      @(posedge clk);
      model_step(r);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      bus.req = '0;
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         n_vec++;
         if (!$onehot0(bus.gnt) || (bus.busy !== (|bus.gnt)) ||
             (bus.busy && bus.gnt[{bus.s1, bus.s0}] !== 1'b1)) begin
            n_err++;
            $display("FAIL invariant: gnt=%b busy=%b sel=%b%b",
                     bus.gnt, bus.busy, bus.s1, bus.s0);
         end
      end
   end

   task automatic test_reset();
      rst_n   = 1'b0;
      bus.req = 4'b1111;
      bus.din = 4'b1111;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.gnt, bus.s1, bus.s0, bus.busy, bus.o} !== 8'h00) begin
         n_err++;
         $display("FAIL reset: got gnt=%b s=%b%b busy=%b o=%b want all 0",
                  bus.gnt, bus.s1, bus.s0, bus.busy, bus.o);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_rotate();
      logic [3:0] exp;
      logic [1:0] es;
      for (int k = 1; k <= 20; k++) begin
         step(4'b1111, 4'b0000);
         es  = 2'(((k - 1) / MH) % 4);
         exp = 4'b0001 << es;
         n_vec++;
         if (bus.gnt !== exp || {bus.s1, bus.s0} !== es ||
             bus.gnt !== m_gnt()) begin
            n_err++;
            $display("FAIL rotate k=%0d: gnt=%b sel=%b%b want gnt=%b sel=%b",
                     k, bus.gnt, bus.s1, bus.s0, exp, es);
         end
      end
   endtask

   task automatic test_single();
      logic [3:0] exp [4];
      logic       bexp [4];
      logic [3:0] rq;
      do_reset();
      exp[0] = 4'b0100; exp[1] = 4'b0100; exp[2] = 4'b0000; exp[3] = 4'b0000;
      bexp[0] = 1'b1;   bexp[1] = 1'b1;   bexp[2] = 1'b0;   bexp[3] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         rq = (k < 2) ? 4'b0100 : 4'b0000;
         step(rq, 4'b0000);
         n_vec++;
         if (bus.gnt !== exp[k] || bus.busy !== bexp[k] ||
             bus.gnt !== m_gnt()) begin
            n_err++;
            $display("FAIL single k=%0d: gnt=%b busy=%b want gnt=%b busy=%b",
                     k, bus.gnt, bus.busy, exp[k], bexp[k]);
         end
      end
      n_vec++;
      if ({bus.s1, bus.s0} !== 2'b10) begin
         n_err++;
         $display("FAIL idle_sel: sel=%b%b want 10", bus.s1, bus.s0);
      end
      step(4'b1001, 4'b0000);
      n_vec++;
      if (bus.gnt !== 4'b1000) begin
         n_err++;
         $display("FAIL ptr_after_drop: gnt=%b want 1000", bus.gnt);
      end
   endtask

   task automatic test_hold();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step(4'b0001, 4'b0000);
         n_vec++;
         if (bus.gnt !== 4'b0001 || bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL hold k=%0d: gnt=%b busy=%b want 0001/1",
                     k, bus.gnt, bus.busy);
         end
      end
   endtask

   task automatic test_data();
      do_reset();
      step(4'b0010, 4'b0000);
      bus.din = 4'b0010;
      #1;
      n_vec++;
      if (bus.o !== 1'b1) begin
         n_err++;
         $display("FAIL data_hi: o=%b want 1", bus.o);
      end
      bus.din = 4'b0000;
      #1;
      n_vec++;
      if (bus.o !== 1'b0) begin
         n_err++;
         $display("FAIL data_lo: o=%b want 0", bus.o);
      end
      step(4'b0000, 4'b1111);
      step(4'b0000, 4'b1111);
      n_vec++;
      if (bus.o !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL data_idle: o=%b busy=%b want 0/0", bus.o, bus.busy);
      end
   endtask

   task automatic test_async();
      do_reset();
      step(4'b1000, 4'b0000);
      n_vec++;
      if (bus.gnt !== 4'b1000) begin
         n_err++;
         $display("FAIL async_pre: gnt=%b want 1000", bus.gnt);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.gnt, bus.busy, bus.s1, bus.s0} !== 7'd0) begin
         n_err++;
         $display("FAIL async_rst: gnt=%b busy=%b s=%b%b want 0",
                  bus.gnt, bus.busy, bus.s1, bus.s0);
      end
      #1;
      rst_n = 1'b1;
      model_reset();
      step(4'b1010, 4'b0000);
      n_vec++;
      if (bus.gnt !== 4'b0010) begin
         n_err++;
         $display("FAIL async_post: gnt=%b want 0010", bus.gnt);
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic [3:0] d;
      logic [3:0] g;
      logic       eo;
      do_reset();
      for (int k = 0; k < 600; k++) begin
         r = 4'($urandom) & 4'($urandom | 32'h5);
         if ($urandom_range(0, 7) == 0) r = '0;
         d = 4'($urandom);
         step(r, d);
         g  = m_gnt();
         eo = (m_owner >= 0) ? d[m_sel] : 1'b0;
         n_vec++;
         if (bus.gnt !== g || {bus.s1, bus.s0} !== 2'(m_sel) ||
             bus.busy !== (m_owner >= 0) || bus.o !== eo) begin
            n_err++;
            $display("FAIL random k=%0d: gnt=%b sel=%b%b o=%b want gnt=%b sel=%0d o=%b",
                     k, bus.gnt, bus.s1, bus.s0, bus.o, g, m_sel, eo);
         end
      end
   endtask

   initial begin
      n_vec   = 0;
      n_err   = 0;
      bus.req = '0;
      bus.din = '0;
      model_reset();
      test_reset();
      test_rotate();
      test_single();
      test_hold();
      test_data();
      test_async();
      test_random();
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
